// File: rtl/mips_pkg.sv
// ============================================================================
// mips_pkg : shared ALU opcodes, register-zero constant and control bundle
// Rev 1.0
// ============================================================================
`default_nettype none

package mips_pkg;

  localparam logic [3:0] ADDU = 4'b0000;
  localparam logic [3:0] SUBU = 4'b0001;
  localparam logic [3:0] SLT  = 4'b0010;
  localparam logic [3:0] AND  = 4'b0011;
  localparam logic [3:0] NOR  = 4'b0100;
  localparam logic [3:0] OR   = 4'b0101;
  localparam logic [3:0] XOR  = 4'b0110;
  localparam logic [3:0] SLL  = 4'b0111;
  localparam logic [3:0] SRL  = 4'b1000;
  localparam logic [3:0] SLTU = 4'b1001;
  localparam logic [3:0] SRA  = 4'b1010;
  localparam logic [3:0] LUI  = 4'b1011;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic regwrite;
    logic memread;
    logic memwrite;
    logic memtoreg;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '{regwrite: 1'b0, memread: 1'b0,
                                  memwrite: 1'b0, memtoreg: 1'b0};

endpackage

`default_nettype wire

// File: rtl/fwd_mux.sv
// ============================================================================
// fwd_mux : single-operand forwarding select, EX/MEM over MEM/WB over regfile
// Rev 1.0
// ============================================================================
`default_nettype none

module fwd_mux
  import mips_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int REGW  = 5
) (
  input  logic [REGW-1:0]  src,
  input  logic [WIDTH-1:0] src_data,
  input  logic             exm_regwrite,
  input  logic [REGW-1:0]  exm_rd,
  input  logic [WIDTH-1:0] exm_result,
  input  logic             mwb_regwrite,
  input  logic [REGW-1:0]  mwb_rd,
  input  logic [WIDTH-1:0] mwb_data,
  output logic [WIDTH-1:0] fwd_data
);

  logic w_exm_hit;
  logic w_mwb_hit;

  // $zero is hardwired, so a pending write to it must never be forwarded
  assign w_exm_hit = exm_regwrite && (exm_rd != REGW'(REG_ZERO)) && (exm_rd == src);
  assign w_mwb_hit = mwb_regwrite && (mwb_rd != REGW'(REG_ZERO)) && (mwb_rd == src);

  always_comb begin
    fwd_data = src_data;
    if (w_exm_hit)
      fwd_data = exm_result;
    else if (w_mwb_hit)
      fwd_data = mwb_data;
  end

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ============================================================================
// id_ex_stage : ID/EX pipeline register with forwarding, operand select and
//               load-use hazard detection feeding the ALU
// Rev 1.0
// ============================================================================
`default_nettype none

module id_ex_stage
  import mips_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int REGW  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [WIDTH-1:0] id_rs_data,
  input  logic [WIDTH-1:0] id_rt_data,
  input  logic [WIDTH-1:0] id_imm,
  input  logic [4:0]       id_shamt,
  input  logic [REGW-1:0]  id_rs,
  input  logic [REGW-1:0]  id_rt,
  input  logic [REGW-1:0]  id_rd,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [3:0]       id_alu_ctr,
  input  logic             id_alusrc,
  input  logic             id_shamt_sel,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             id_memwrite,
  input  logic             id_memtoreg,
  input  logic             ex_hold,
  input  logic             flush,
  input  logic             exm_regwrite,
  input  logic [REGW-1:0]  exm_rd,
  input  logic [WIDTH-1:0] exm_result,
  input  logic             mwb_regwrite,
  input  logic [REGW-1:0]  mwb_rd,
  input  logic [WIDTH-1:0] mwb_data,
  output logic             ex_valid,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_ctr,
  output logic [WIDTH-1:0] ex_store_data,
  output logic [REGW-1:0]  ex_rd,
  output logic             ex_regwrite,
  output logic             ex_memread,
  output logic             ex_memwrite,
  output logic             ex_memtoreg,
  output logic             load_use_stall
);

  logic             r_valid;
  logic [WIDTH-1:0] r_rs_data;
  logic [WIDTH-1:0] r_rt_data;
  logic [WIDTH-1:0] r_imm;
  logic [4:0]       r_shamt;
  logic [REGW-1:0]  r_rs;
  logic [REGW-1:0]  r_rt;
  logic [REGW-1:0]  r_rd;
  logic [3:0]       r_alu_ctr;
  logic             r_alusrc;
  logic             r_shamt_sel;
  ctrl_t            r_ctrl;

  ctrl_t            w_id_ctrl;
  logic [WIDTH-1:0] w_fwd_rs;
  logic [WIDTH-1:0] w_fwd_rt;
  logic             w_src_match;

  assign w_id_ctrl = '{regwrite: id_regwrite, memread: id_memread,
                       memwrite: id_memwrite, memtoreg: id_memtoreg};

  // Hazard check against the load sitting in EX; suppressed under ex_hold so
  // the frozen stage is not turned into a bubble.
  assign w_src_match = (id_uses_rs && (id_rs == r_rd)) || (id_uses_rt && (id_rt == r_rd));
  assign load_use_stall = !ex_hold && r_valid && r_ctrl.memread
                          && (r_rd != REGW'(REG_ZERO)) && id_valid && w_src_match;

  // Bubbles clear only valid, control and opcode; datapath fields are don't-care.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= 1'b0;
      r_rs_data   <= '0;
      r_rt_data   <= '0;
      r_imm       <= '0;
      r_shamt     <= '0;
      r_rs        <= '0;
      r_rt        <= '0;
      r_rd        <= '0;
      r_alu_ctr   <= ADDU;
      r_alusrc    <= 1'b0;
      r_shamt_sel <= 1'b0;
      r_ctrl      <= CTRL_NONE;
    end else if (flush) begin
      r_valid   <= 1'b0;
      r_alu_ctr <= ADDU;
      r_ctrl    <= CTRL_NONE;
    end else if (ex_hold) begin
      r_valid <= r_valid;
    end else if (load_use_stall) begin
      r_valid   <= 1'b0;
      r_alu_ctr <= ADDU;
      r_ctrl    <= CTRL_NONE;
    end else begin
      r_valid     <= id_valid;
      r_rs_data   <= id_rs_data;
      r_rt_data   <= id_rt_data;
      r_imm       <= id_imm;
      r_shamt     <= id_shamt;
      r_rs        <= id_rs;
      r_rt        <= id_rt;
      r_rd        <= id_rd;
      r_alu_ctr   <= id_alu_ctr;
      r_alusrc    <= id_alusrc;
      r_shamt_sel <= id_shamt_sel;
      r_ctrl      <= w_id_ctrl;
    end
  end

  fwd_mux #(.WIDTH(WIDTH), .REGW(REGW)) u_fwd_rs (
    .src          (r_rs),
    .src_data     (r_rs_data),
    .exm_regwrite (exm_regwrite),
    .exm_rd       (exm_rd),
    .exm_result   (exm_result),
    .mwb_regwrite (mwb_regwrite),
    .mwb_rd       (mwb_rd),
    .mwb_data     (mwb_data),
    .fwd_data     (w_fwd_rs)
  );

  fwd_mux #(.WIDTH(WIDTH), .REGW(REGW)) u_fwd_rt (
    .src          (r_rt),
    .src_data     (r_rt_data),
    .exm_regwrite (exm_regwrite),
    .exm_rd       (exm_rd),
    .exm_result   (exm_result),
    .mwb_regwrite (mwb_regwrite),
    .mwb_rd       (mwb_rd),
    .mwb_data     (mwb_data),
    .fwd_data     (w_fwd_rt)
  );

  // Shifts take the amount on A and the value on B.
  assign alu_a         = r_shamt_sel ? {{(WIDTH-5){1'b0}}, r_shamt} : w_fwd_rs;
  assign alu_b         = r_alusrc ? r_imm : w_fwd_rt;
  assign ex_store_data = w_fwd_rt;
  assign alu_ctr       = r_alu_ctr;
  assign ex_rd         = r_rd;
  assign ex_valid      = r_valid;

  assign ex_regwrite = r_valid && r_ctrl.regwrite;
  assign ex_memread  = r_valid && r_ctrl.memread;
  assign ex_memwrite = r_valid && r_ctrl.memwrite;
  assign ex_memtoreg = r_valid && r_ctrl.memtoreg;

endmodule

`default_nettype wire

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register and EX-stage operand front end for the 5-stage MIPS datapath.
- Captures decoded fields from ID and resolves EX/MEM and MEM/WB forwarding.
- Drives the ALU's A, B and ALUctr inputs directly.
- Detects load-use hazards, and handles hold, flush and bubble insertion.

Parameters:
- WIDTH, 32, datapath width
- REGW, 5, register-address width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs_data, id_rt_data  in  WIDTH  register-file read data
- id_imm  in  WIDTH  extended immediate (LUI: raw imm in [15:0])
- id_shamt  in  5  shift amount field
- id_rs, id_rt, id_rd  in  REGW  source addresses / destination address (already rt-or-rd selected)
- id_uses_rs, id_uses_rt  in  1  operand actually read
- id_alu_ctr  in  4  ALU opcode
- id_alusrc  in  1  B := immediate
- id_shamt_sel  in  1  A := zero-extended shamt (sll/srl/sra)
- id_regwrite, id_memread, id_memwrite, id_memtoreg  in  1  control bits
- ex_hold  in  1  downstream stall; freeze stage
- flush  in  1  kill instruction entering EX
- exm_regwrite  in  1  EX/MEM writeback enable
- exm_rd  in  REGW  EX/MEM destination
- exm_result  in  WIDTH  EX/MEM ALU result
- mwb_regwrite  in  1  MEM/WB writeback enable
- mwb_rd  in  REGW  MEM/WB destination
- mwb_data  in  WIDTH  MEM/WB writeback data
- ex_valid  out  1  EX holds a real instruction
- alu_a, alu_b  out  WIDTH  ALU operands (combinational from registers plus forwarding)
- alu_ctr  out  4  ALU opcode
- ex_store_data  out  WIDTH  forwarded rt value for sw
- ex_rd  out  REGW  destination
- ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg  out  1  control, gated by ex_valid
- load_use_stall  out  1  request: ID/IF hold one cycle

Behaviour:
- Reset (async, rst_n=0):
  - All registered state cleared; ex_valid=0; alu_ctr=4'b0000; ex_rd=0; all control bits 0.
  - alu_a, alu_b and ex_store_data then evaluate to 0.
  - rst_n asserted mid-instruction discards it; no partial state survives.
- Register update on each rising edge, first match wins:
  1. flush=1 -> bubble: valid=0, control bits 0, alu_ctr=0000.
  2. ex_hold=1 -> all registers keep their values.
  3. load_use_stall=1 -> bubble, same as flush.
  4. Otherwise -> load all id_* fields; valid := id_valid.
- Latency: one cycle ID->EX. A bubble drives ex_regwrite=ex_memread=ex_memwrite=0, so it is architecturally invisible.
- Forwarding, combinational, per source; EX/MEM has priority over MEM/WB:
  - fwd_rs = exm_result if exm_regwrite && exm_rd!=0 && exm_rd==rs_q
  - else mwb_data if mwb_regwrite && mwb_rd!=0 && mwb_rd==rs_q
  - else rs_data_q
  - fwd_rt is identical using rt_q.
  - Register 0 is never forwarded.
- Operand select (ALU convention: shifts use A = amount, B = value):
  - alu_a = shamt_sel_q ? {WIDTH-5 zeros, shamt_q} : fwd_rs
  - alu_b = alusrc_q ? imm_q : fwd_rt
  - ex_store_data = fwd_rt always.
  - sllv/srlv/srav use shamt_sel=0; only A[4:0] is meaningful to the ALU.
- Load-use detect, combinational:
  - load_use_stall = ex_valid && ex_memread_q && ex_rd!=0 && id_valid && ((id_uses_rs && id_rs==ex_rd) || (id_uses_rt && id_rt==ex_rd))
  - Forced 0 while ex_hold=1, so the upstream stall comes from ex_hold instead and the stage contents are preserved.
  - After one bubble, the load is in MEM and its data arrives via MEM/WB forwarding in the following cycle.
- Simultaneous events:
  - flush with ex_hold: flush wins.
  - flush with load_use: bubble; the upstream hold is still asserted but is harmless because ID is also flushed by its own logic.

Decomposition:
- Shared package mips_pkg:
  - ALUctr localparams: ADDU=0000, SUBU=0001, SLT=0010, AND=0011, NOR=0100, OR=0101, XOR=0110, SLL=0111, SRL=1000, SLTU=1001, SRA=1010, LUI=1011.
  - REG_ZERO=5'd0.
- One sub-module: fwd_mux (single-operand forwarding select), instantiated twice (rs, rt).

Test Plan:
- Reset: rst_n low mid-stream -> ex_valid=0, alu_ctr=0000, alu_a=alu_b=0 immediately, without waiting for a clock edge.
- Back-to-back ALU:
  - Stimulus: EX/MEM holds addu $3 (exm_result=0x10), EX holds subu $4,$3,$3, MEM/WB also writes $3=0x99.
  - Response: alu_a=alu_b=0x10 (EX/MEM priority).
- Load-use:
  - Stimulus: lw $5 in EX, ID issues or $6,$5,$0.
  - Response: load_use_stall=1 for one cycle; next cycle ex_valid=0 (bubble).
  - Following cycle: or enters EX with mwb_data=0xDEADBEEF forwarded to alu_a.
- Shift:
  - Stimulus: sll $2,$7,4 with $7=0x1, id_shamt_sel=1, id_alusrc=0.
  - Response: alu_a=0x4, alu_b=0x1, alu_ctr=0111.
- Zero register: exm_rd=0, exm_regwrite=1, rs_q=0, rs_data_q=0 -> alu_a=0, not exm_result.
- Hold/flush:
  - ex_hold=1 for 3 cycles -> all outputs stable.
  - flush and ex_hold asserted together -> ex_valid=0 and ex_regwrite=0 next edge.
